// File: rtl/intra16_mb_scheduler.sv
// rtl/intra16_mb_scheduler.sv - raster-order macroblock sequencer for the luma 16x16 extractor and intra predictor
// Optional INTRA16_SCHED_PERF_EN adds the stall_cycles counter output.
module intra16_mb_scheduler #(
  parameter int LENGTH      = 256,
  parameter int WIDTH       = 256,
  parameter int EXTRACT_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        ext_enable,
  output logic [12:0] mbnumber,
  output logic [7:0]  mb_x,
  output logic [7:0]  mb_y,
  output logic        top_avail,
  output logic        left_avail,
  output logic        pred_valid,
  input  logic        pred_ready,
  input  logic        pred_done,
  output logic        busy,
  output logic        frame_done
`ifdef INTRA16_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int MB_COLS = WIDTH / 16;
  localparam int MB_ROWS = LENGTH / 16;
  localparam int NUM_MB  = MB_COLS * MB_ROWS;
  localparam int CNT_W   = (EXTRACT_LAT > 1) ? $clog2(EXTRACT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXTRACT_LAT - 1);
  localparam logic [12:0]      MB_LAST  = 13'(NUM_MB - 1);
  localparam logic [7:0]       COL_LAST = 8'(MB_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [12:0]      mbn_q, mbn_d;
  logic [7:0]       mbx_q, mbx_d;
  logic [7:0]       mby_q, mby_d;
  logic             ext_en_q, pvalid_q, busy_q, fdone_q, top_q, left_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mbn_d   = mbn_q;
    mbx_d   = mbx_q;
    mby_d   = mby_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          mbn_d   = '0;
          mbx_d   = '0;
          mby_d   = '0;
        end
      end
      S_FETCH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ISSUE: begin
        if (pred_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pred_done) begin
          if (mbn_q == MB_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            mbn_d   = mbn_q + 13'd1;
            // Column/row kept as counters so no divider is needed
            if (mbx_q == COL_LAST) begin
              mbx_d = '0;
              mby_d = mby_q + 8'd1;
            end else begin
              mbx_d = mbx_q + 8'd1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      mbn_d   = '0;
      mbx_d   = '0;
      mby_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mbn_q    <= '0;
      mbx_q    <= '0;
      mby_q    <= '0;
      ext_en_q <= 1'b0;
      pvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      top_q    <= 1'b0;
      left_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mbn_q    <= mbn_d;
      mbx_q    <= mbx_d;
      mby_q    <= mby_d;
      ext_en_q <= (state_d == S_FETCH);
      pvalid_q <= (state_d == S_ISSUE);
      busy_q   <= (state_d != S_IDLE);
      fdone_q  <= (state_d == S_DONE);
      top_q    <= (mby_d != 8'd0);
      left_q   <= (mbx_d != 8'd0);
    end
  end

  assign ext_enable = ext_en_q;
  assign mbnumber   = mbn_q;
  assign mb_x       = mbx_q;
  assign mb_y       = mby_q;
  assign top_avail  = top_q;
  assign left_avail = left_q;
  assign pred_valid = pvalid_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;

`ifdef INTRA16_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (((state_q == S_ISSUE) && !pred_ready) || ((state_q == S_WAIT) && !pred_done)) begin
      if (stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
    end
    if ((state_q == S_IDLE) && start) stall_d = '0;
    if (abort) stall_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/intra16_mb_scheduler.md
Name: intra16_mb_scheduler

Overview:
- Frame-level controller that sequences the luma 16x16 macroblock extractor through every macroblock of a LENGTH x WIDTH frame in raster order.
- Drives the extractor's enable and mbnumber inputs and waits out its fixed fetch latency.
- Then hands the macroblock to the downstream intra predictor / mode-decision stage with a valid/ready handshake.
- Advances to the next macroblock only after the predictor reports done.

Parameters:
- LENGTH, 256, frame height in pixels (multiple of 16).
- WIDTH, 256, frame width in pixels (multiple of 16).
- EXTRACT_LAT, 3, cycles ext_enable must stay high before extractor outputs are valid (>=1).
- Derived: MB_COLS = WIDTH/16; MB_ROWS = LENGTH/16; NUM_MB = MB_COLS*MB_ROWS (<= 8192).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse: begin a frame; honoured only in IDLE.
- abort  input  1  synchronous abort of the current frame.
- ext_enable  output  1  enable to the extractor.
- mbnumber  output  13  current macroblock index, to the extractor.
- mb_x  output  8  mbnumber % MB_COLS.
- mb_y  output  8  mbnumber / MB_COLS.
- top_avail  output  1  mb_y != 0.
- left_avail  output  1  mb_x != 0.
- pred_valid  output  1  extractor outputs (mb, toppixels, leftpixels) are valid for the predictor.
- pred_ready  input  1  predictor accepts the macroblock.
- pred_done  input  1  pulse: predictor finished the current macroblock.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse after the last macroblock completes.

Behaviour:
- Reset (reset=0, async): state=IDLE; mbnumber=0, mb_x=0, mb_y=0, fetch counter=0.
  - ext_enable, pred_valid, busy and frame_done all 0.
  - top_avail and left_avail are 0, consistent with MB 0.
- Outputs are registered. mb_x and mb_y are maintained as counters, not divided.
  - mb_x wraps from MB_COLS-1 to 0, and mb_y then increments.
- IDLE:
  - start=1 -> FETCH; mbnumber, mb_x, mb_y and counter cleared.
  - Otherwise stay in IDLE.
- FETCH:
  - ext_enable=1 and counter increments each cycle.
  - When counter==EXTRACT_LAT-1 -> ISSUE, counter cleared.
- ISSUE:
  - ext_enable=0 and pred_valid=1. pred_valid is held until pred_ready is sampled high.
  - On valid&&ready -> WAIT, and pred_valid drops the next cycle.
- WAIT:
  - Wait for pred_done.
  - If pred_done and mbnumber==NUM_MB-1 -> DONE.
  - If pred_done otherwise -> mbnumber+1 (with mb_x/mb_y update) and FETCH.
- DONE: frame_done=1 for exactly one cycle -> IDLE. mbnumber stays at NUM_MB-1.
- Per-MB overhead with ready and done immediate: EXTRACT_LAT + 2 cycles, i.e. 5 at default.
- Boundary rules:
  - start while busy: ignored.
  - pred_done outside WAIT: ignored.
  - pred_ready outside ISSUE: ignored.
  - abort (any state): next cycle IDLE, all outputs back to reset values except mbnumber, which is cleared. No frame_done is emitted.
  - abort together with pred_done or start: abort wins.
  - Async reset mid-frame: immediate return to reset values. No partial handshake survives.
- NUM_MB=1: FETCH -> ISSUE -> WAIT -> DONE with no increment.

Optional Feature:
- Macro: INTRA16_SCHED_PERF_EN.
- When defined:
  - Adds output stall_cycles [31:0], counting cycles spent in ISSUE with pred_ready=0 plus cycles in WAIT with pred_done=0.
  - Cleared on reset and on an accepted start; saturates at 32'hFFFFFFFF.
  - Holds its value in IDLE.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- LENGTH=WIDTH=32 (4 MBs), start pulse, pred_ready=1, pred_done pulsed on the first WAIT cycle:
  - mbnumber sequence is 0,1,2,3.
  - (mb_x,mb_y) sequence is (0,0),(1,0),(0,1),(1,1).
  - top/left avail are 00,01,10,11.
  - ext_enable is high 3 cycles per MB.
  - frame_done pulses once, 20 cycles after start is sampled.
- pred_ready held low 7 cycles in ISSUE -> pred_valid stays high 8 cycles; no advance; with PERF_EN, stall_cycles=7.
- abort asserted in WAIT of MB 2, same cycle as pred_done -> IDLE next cycle, mbnumber=0, busy=0, no frame_done.
- start pulsed again during FETCH of MB 1 -> ignored; frame completes normally with a single frame_done.
- reset driven low mid-FETCH between clock edges -> ext_enable=0 and state IDLE immediately (before the next edge); after reset release with no start, stays idle.
- Default 256x256, pred always ready/done -> 256 MBs, last mbnumber=255 (mb_x=15, mb_y=15), frame_done after 1280 cycles.
